// File: rtl/cpu_types_pkg.sv
// Shared CPU control types for the pipeline controller slice.
// Contents: controller FSM state enum, register-index type and the
// default widths used by the controller, its interface and sub-blocks.
package cpu_types_pkg;

  localparam int REGW_DEF = 5;
  localparam int CNTW_DEF = 32;

  typedef logic [REGW_DEF-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } pctl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the datapath and the pipeline controller.
// Hazard inputs (datapath -> controller):
//   ihit, dhit, id_rs, id_rt, ex_rd, ex_dREN, ex_regWr, ex_jump,
//   mem_dREN, mem_dWEN, mem_brTaken, mem_halt
// Control outputs (controller -> datapath):
//   pc_en, {ifid,idex,exmem,memwb}_en, {ifid,idex,exmem,memwb}_flush,
//   halted, stall_cnt
// master = datapath side, slave = controller side.
interface pipeline_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_dREN;
  logic             ex_regWr;
  logic             ex_jump;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             mem_brTaken;
  logic             mem_halt;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, dhit, id_rs, id_rt, ex_rd, ex_dREN, ex_regWr, ex_jump,
           mem_dREN, mem_dWEN, mem_brTaken, mem_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cnt
  );

  modport slave (
    input  ihit, dhit, id_rs, id_rt, ex_rd, ex_dREN, ex_regWr, ex_jump,
           mem_dREN, mem_dWEN, mem_brTaken, mem_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_load_use.sv
// Load-use hazard comparator (purely combinational).
// Ports:
//   exDRen, exRegWr : instruction in EX is a load that writes a register
//   exRd            : its destination register
//   idRs, idRt      : source registers of the instruction in ID
//   lu_stall        : ID must wait one cycle for the load result
module load_use_detect
  import cpu_types_pkg::*;
#(
  parameter int REG_W = REGW_DEF
) (
  input  logic             exDRen,
  input  logic             exRegWr,
  input  logic [REG_W-1:0] exRd,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  output logic             lu_stall
);

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign lu_stall = exDRen & exRegWr & (exRd != '0) &
                    ((exRd == idRs) | (exRd == idRt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: latch enables/flushes, PC write enable,
// data-memory wait FSM, sticky halt and a saturating stall-cycle counter.
// Ports:
//   CLK  : clock, all state on rising edge
//   RST  : asynchronous active-high reset
//   bus  : pipeline_ctrl_if.slave (hazard inputs, control outputs)
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | normal issue; priority hazard mux active
// MEMWAIT | data access outstanding; whole pipe frozen until dhit
// HALT    | halt retired; pipe frozen, halted=1 until reset
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_W = REGW_DEF,
  parameter int CNT_W = CNTW_DEF
) (
  input logic            CLK,
  input logic            RST,
  pipeline_ctrl_if.slave bus
);

  pctl_state_t      state, nextState;
  logic             luStall;
  logic             evalHazards;
  logic             pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic             ifidFl, idexFl, exmemFl, memwbFl;
  logic [CNT_W-1:0] stallCnt;

  load_use_detect #(.REG_W(REG_W)) uLoadUse (
    .exDRen   (bus.ex_dREN),
    .exRegWr  (bus.ex_regWr),
    .exRd     (bus.ex_rd),
    .idRs     (bus.id_rs),
    .idRt     (bus.id_rt),
    .lu_stall (luStall)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= nextState;
  end

  always_comb begin
    nextState   = state;
    evalHazards = 1'b0;
    pcEn        = 1'b1;
    ifidEn      = 1'b1;
    idexEn      = 1'b1;
    exmemEn     = 1'b1;
    memwbEn     = 1'b1;
    ifidFl      = 1'b0;
    idexFl      = 1'b0;
    exmemFl     = 1'b0;
    memwbFl     = 1'b0;

    case (state)
      RUN: begin
        if (bus.mem_halt) begin
          // only MEM/WB moves so the halt itself retires
          {pcEn, ifidEn, idexEn, exmemEn} = '0;
          nextState = HALT;
        end else if ((bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit) begin
          {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = '0;
          nextState = MEMWAIT;
        end else begin
          evalHazards = 1'b1;
        end
      end
      MEMWAIT: begin
        if (bus.dhit) begin
          evalHazards = 1'b1;
          nextState   = RUN;
        end else begin
          {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = '0;
        end
      end
      HALT: begin
        {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = '0;
      end
      default: begin
        nextState = RUN;
      end
    endcase

    // Control hazards outrank load-use: the flush already removes the
    // dependent instruction, so no bubble is needed.
    if (evalHazards) begin
      if (bus.mem_brTaken) begin
        {ifidFl, idexFl, exmemFl} = 3'b111;
      end else if (bus.ex_jump) begin
        {ifidFl, idexFl} = 2'b11;
      end else if (luStall) begin
        pcEn   = 1'b0;
        ifidEn = 1'b0;
        idexFl = 1'b1;
      end else if (!bus.ihit) begin
        pcEn   = 1'b0;
        ifidFl = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stallCnt <= '0;
    end else if (!pcEn && (state != HALT) && !(&stallCnt)) begin
      stallCnt <= stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Reset forces the pipe into a frozen, cleared condition.
  assign bus.pc_en       = pcEn    & ~RST;
  assign bus.ifid_en     = ifidEn  & ~RST;
  assign bus.idex_en     = idexEn  & ~RST;
  assign bus.exmem_en    = exmemEn & ~RST;
  assign bus.memwb_en    = memwbEn & ~RST;
  assign bus.ifid_flush  = ifidFl  | RST;
  assign bus.idex_flush  = idexFl  | RST;
  assign bus.exmem_flush = exmemFl | RST;
  assign bus.memwb_flush = memwbFl | RST;
  assign bus.halted      = (state == HALT);
  assign bus.stall_cnt   = stallCnt;

endmodule
